// File: rtl/debug_word_tx_pkg.sv
// Shared definitions for the debug UART link (transmitter here, receiver in
// the debug unit): serializer state encodings, debug word width and the
// default line settings.
package debug_word_tx_pkg;

    localparam int DBG_WORD_W    = 32;
    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_BAUD      = 9600;
    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/debug_word_tx_if.sv
// Word-level handshake and line signals of the debug word transmitter.
//   in_word   : word to send (source -> transmitter)
//   in_valid  : source has a word
//   out_ready : transmitter can accept a word
//   tx        : serial line, idle high
//   busy      : word in progress
//   out_done  : one-cycle pulse when the final stop bit of a word completes
// master = debug-unit sequencer side, slave = transmitter side.
interface debug_word_tx_if #(
    parameter int NBYTES = 4
);
    logic [8*NBYTES-1:0] in_word;
    logic                in_valid;
    logic                out_ready;
    logic                tx;
    logic                busy;
    logic                out_done;

    modport master (
        output in_word, in_valid,
        input  out_ready, tx, busy, out_done
    );

    modport slave (
        input  in_word, in_valid,
        output out_ready, tx, busy, out_done
    );
endinterface

// File: rtl/debug_word_tx_uart_tx_byte.sv
// 8N1 byte serializer with its own baud counter.
//   clk, rst : system clock, synchronous active-high reset
//   byte_i   : byte to send, taken when valid_i && ready_o
//   valid_i  : a byte is offered
//   ready_o  : idle, or in the last cycle of a stop bit (allows gapless bytes)
//   tx_o     : registered serial output, idle high
//   done_o   : high in the last cycle of the stop bit
module uart_tx_byte
    import debug_word_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       done_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             bit_tick;

    assign bit_tick = (cnt_q == CNT_LAST);
    assign ready_o  = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tick);
    assign done_o   = (state_q == ST_STOP) && bit_tick;
    assign tx_o     = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_tick ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (valid_i) begin
                    state_d = ST_START;
                    data_d  = byte_i;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_tick) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                tx_d = data_q[bit_q];
                if (bit_tick) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;   // wraps 7->0 on leaving DATA
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (valid_i) begin
                        state_d = ST_START;
                        data_d  = byte_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx is registered from the current state, so it trails the state by
    // one cycle: the start bit appears on the edge after the state enters START.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
endmodule

// File: rtl/debug_word_tx.sv
// Debug word transmitter: takes a word over valid/ready and sends it as
// NBYTES UART 8N1 bytes, least-significant byte first, with no gap between
// the bytes of one word.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of debug_word_tx_if (in_word, in_valid, out_ready,
//              tx, busy, out_done)
module debug_word_tx
    import debug_word_tx_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int NBYTES   = DBG_WORD_W / BITS_PER_BYTE
) (
    input  logic           clk,
    input  logic           rst,
    debug_word_tx_if.slave bus
);
    localparam int WORD_W       = 8 * NBYTES;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int IDX_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    logic              active_q, active_d;
    logic              out_done_q, out_done_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_byte, accept;
    logic              byte_valid, byte_ready, byte_done;
    logic [7:0]        byte_data;

    assign last_byte = (byte_idx_q == IDX_LAST);
    assign accept    = !active_q && bus.in_valid && byte_ready;

    // When idle the first byte goes straight from in_word; afterwards the
    // low byte of word_q is always the next byte, offered during the stop
    // bit so the serializer chains it without an idle cycle.
    assign byte_valid = active_q ? !last_byte : bus.in_valid;
    assign byte_data  = active_q ? word_q[7:0] : bus.in_word[7:0];

    always_comb begin
        active_d   = active_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        out_done_d = 1'b0;
        if (accept) begin
            active_d   = 1'b1;
            byte_idx_d = '0;
            word_d     = bus.in_word >> 8;
        end else if (active_q && byte_done) begin
            if (last_byte) begin
                active_d   = 1'b0;
                out_done_d = 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + 1'b1;
                word_d     = word_q >> 8;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            byte_idx_q <= '0;
            out_done_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            byte_idx_q <= byte_idx_d;
            out_done_q <= out_done_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .rst    (rst),
        .byte_i (byte_data),
        .valid_i(byte_valid),
        .ready_o(byte_ready),
        .tx_o   (bus.tx),
        .done_o (byte_done)
    );

    assign bus.out_ready = !active_q;
    assign bus.busy      = active_q;
    assign bus.out_done  = out_done_q;
endmodule
